// File: rtl/arb_pkg.sv
// Shared types and defaults for the round-robin one-hot arbiter.
package arb_pkg;

    localparam int ARB_N_DEFAULT = 8;

    typedef enum logic {
        ARB_IDLE,
        ARB_GRANT
    } arb_state_t;

endpackage : arb_pkg

// File: rtl/rr_pick.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping.
// The request vector is doubled so the wrap becomes a plain priority scan.
module rr_pick #(
    parameter int N     = 8,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     pick_onehot,
    output logic [IDX_W-1:0] pick_idx,
    output logic             pick_any
);

    logic [2*N-1:0] req_dbl;
    logic [2*N-1:0] req_masked;
    logic           found;

    assign req_dbl = {req, req};

    // Bits below ptr in the lower copy are masked; their turn comes in the upper copy.
    always_comb begin
        req_masked = '0;
        for (int i = 0; i < 2*N; i++) begin
            req_masked[i] = req_dbl[i] && (i >= int'(ptr));
        end
    end

    always_comb begin
        pick_onehot = '0;
        pick_idx    = '0;
        found       = 1'b0;
        for (int i = 0; i < 2*N; i++) begin
            if (!found && req_masked[i]) begin
                found                = 1'b1;
                pick_idx             = IDX_W'(i % N);
                pick_onehot[i % N]   = 1'b1;
            end
        end
    end

    assign pick_any = |req;

endmodule : rr_pick

// File: rtl/rr_onehot_arbiter.sv
// Round-robin arbiter with a registered one-hot grant held under valid/ready.
// Optional bus-lock (macro RR_ARB_LOCK_EN) re-grants the locked requester first.
module rr_onehot_arbiter
    import arb_pkg::*;
#(
    parameter int N = ARB_N_DEFAULT
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    input  logic         gnt_ready,
`ifdef RR_ARB_LOCK_EN
    input  logic         lock,
`endif
    output logic [N-1:0] gnt_onehot,
    output logic         gnt_valid,
    output logic         busy
);

    localparam int IDX_W = $clog2(N);

    arb_state_t       state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [N-1:0]     gnt_q, gnt_d;

    logic [IDX_W-1:0] scan_ptr;
    logic [IDX_W-1:0] next_ptr;
    logic [N-1:0]     pick_onehot;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_any;
    logic             accept;
    logic             lock_hit;

`ifdef RR_ARB_LOCK_EN
    assign lock_hit = lock;
`else
    assign lock_hit = 1'b0;
`endif

    assign accept   = (state_q == ARB_GRANT) && gnt_ready;
    assign next_ptr = idx_q + IDX_W'(1);

    // Locked accept keeps ptr but scans from the granted index so it wins again.
    always_comb begin
        scan_ptr = ptr_q;
        if (accept) begin
            scan_ptr = lock_hit ? idx_q : next_ptr;
        end
    end

    rr_pick #(
        .N     (N),
        .IDX_W (IDX_W)
    ) u_pick (
        .req         (req),
        .ptr         (scan_ptr),
        .pick_onehot (pick_onehot),
        .pick_idx    (pick_idx),
        .pick_any    (pick_any)
    );

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        idx_d   = idx_q;
        gnt_d   = gnt_q;
        unique case (state_q)
            ARB_IDLE: begin
                if (pick_any) begin
                    state_d = ARB_GRANT;
                    gnt_d   = pick_onehot;
                    idx_d   = pick_idx;
                end
            end
            ARB_GRANT: begin
                if (gnt_ready) begin
                    ptr_d = lock_hit ? ptr_q : next_ptr;
                    if (pick_any) begin
                        gnt_d = pick_onehot;
                        idx_d = pick_idx;
                    end else begin
                        state_d = ARB_IDLE;
                        gnt_d   = '0;
                    end
                end
            end
            default: begin
                state_d = ARB_IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ARB_IDLE;
            ptr_q   <= '0;
            gnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
        end
    end

    // Granted index is only consulted while in GRANT, so it needs no reset.
    always_ff @(posedge clk) begin
        idx_q <= idx_d;
    end

    assign gnt_onehot = gnt_q;
    assign gnt_valid  = (state_q == ARB_GRANT);
    assign busy       = (state_q == ARB_GRANT);

endmodule : rr_onehot_arbiter

// File: tb/tb_rr_onehot_arbiter.sv
// Scoreboard bench for rr_onehot_arbiter: a reference model queues expected outputs.
module tb_rr_onehot_arbiter;

    localparam int N = 8;

    logic         clk;
    logic         rst_n;
    logic [N-1:0] req;
    logic         gnt_ready;
    logic         lock;
    logic [N-1:0] gnt_onehot;
    logic         gnt_valid;
    logic         busy;

    int n_vec;
    int n_err;

    typedef struct packed {
        logic         vld;
        logic [N-1:0] gnt;
    } exp_t;

    exp_t exp_q[$];

    // reference model state
    logic         m_valid;
    logic [N-1:0] m_gnt;
    int           m_idx;
    int           m_ptr;

    rr_onehot_arbiter #(.N(N)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .gnt_ready  (gnt_ready),
`ifdef RR_ARB_LOCK_EN
        .lock       (lock),
`endif
        .gnt_onehot (gnt_onehot),
        .gnt_valid  (gnt_valid),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic int ref_pick(input int start, input logic [N-1:0] r);
        for (int k = 0; k < N; k++) begin
            if (r[(start + k) % N]) return (start + k) % N;
        end
        return -1;
    endfunction

    task automatic model(input logic r_n, input logic [N-1:0] r, input logic rdy, input logic lk);
        int  sp;
        int  p;
        logic lk_on;
`ifdef RR_ARB_LOCK_EN
        lk_on = lk;
`else
        lk_on = 1'b0;
`endif
        if (!r_n) begin
            m_valid = 1'b0;
            m_gnt   = '0;
            m_ptr   = 0;
        end else if (!m_valid) begin
            p = ref_pick(m_ptr, r);
            if (p >= 0) begin
                m_idx   = p;
                m_gnt   = '0;
                m_gnt[p] = 1'b1;
                m_valid = 1'b1;
            end
        end else if (rdy) begin
            sp = lk_on ? m_idx : (m_idx + 1) % N;
            if (!lk_on) m_ptr = (m_idx + 1) % N;
            p = ref_pick(sp, r);
            if (p >= 0) begin
                m_idx   = p;
                m_gnt   = '0;
                m_gnt[p] = 1'b1;
            end else begin
                m_valid = 1'b0;
                m_gnt   = '0;
            end
        end
    endtask

    task automatic step(input logic r_n, input logic [N-1:0] r, input logic rdy, input logic lk);
        exp_t e;
        @(negedge clk);
        rst_n     = r_n;
        req       = r;
        gnt_ready = rdy;
        lock      = lk;
        model(r_n, r, rdy, lk);
        exp_q.push_back('{vld: m_valid, gnt: m_gnt});
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            chk("sb_empty", 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            chk("gnt_onehot", 32'(gnt_onehot), 32'(e.gnt));
            chk("gnt_valid",  32'(gnt_valid),  32'(e.vld));
            chk("busy",       32'(busy),       32'(e.vld));
            chk("onehot0",    32'($onehot0(gnt_onehot)), 32'd1);
        end
    endtask

    initial begin
        n_vec     = 0;
        n_err     = 0;
        rst_n     = 1'b0;
        req       = '0;
        gnt_ready = 1'b0;
        lock      = 1'b0;
        m_valid   = 1'b0;
        m_gnt     = '0;
        m_idx     = 0;
        m_ptr     = 0;

        // reset, then idle with no requests
        step(1'b0, 8'h00, 1'b0, 1'b0);
        chk("rst_valid", 32'(gnt_valid), 32'd0);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 8'h00, 1'b0, 1'b0);
            chk("idle_gnt", 32'(gnt_onehot), 32'd0);
        end

        // two requesters with wrap
        step(1'b1, 8'b0010_0100, 1'b1, 1'b0);
        chk("pair_g0", 32'(gnt_onehot), 32'h04);
        step(1'b1, 8'b0010_0100, 1'b1, 1'b0);
        chk("pair_g1", 32'(gnt_onehot), 32'h20);
        step(1'b1, 8'b0010_0100, 1'b1, 1'b0);
        chk("pair_g2", 32'(gnt_onehot), 32'h04);

        // all requesting: strict rotation 0..7, 0..7
        step(1'b0, 8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 8'hFF, 1'b1, 1'b0);
            chk("rot_gnt", 32'(gnt_onehot), 32'(1 << (i % N)));
            chk("rot_vld", 32'(gnt_valid), 32'd1);
        end

        // held grant ignores req changes until accepted
        step(1'b0, 8'h00, 1'b0, 1'b0);
        step(1'b1, 8'b0000_1000, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 8'b1000_0000, 1'b0, 1'b0);
            chk("hold_gnt", 32'(gnt_onehot), 32'h08);
        end
        step(1'b1, 8'b1000_0000, 1'b1, 1'b0);
        chk("hold_next", 32'(gnt_onehot), 32'h80);

        // reset mid-grant drops grant and restores ptr=0
        step(1'b0, 8'hFF, 1'b1, 1'b0);
        chk("rst_mid_vld", 32'(gnt_valid), 32'd0);
        step(1'b1, 8'hFF, 1'b1, 1'b0);
        chk("rst_mid_first", 32'(gnt_onehot), 32'h01);

        // drain to idle, gnt_ready while idle leaves ptr alone
        step(1'b1, 8'h00, 1'b1, 1'b0);
        step(1'b1, 8'h00, 1'b1, 1'b0);
        step(1'b1, 8'h00, 1'b1, 1'b0);
        step(1'b1, 8'b0000_0011, 1'b0, 1'b0);
        chk("idle_rdy_ptr", 32'(gnt_onehot), 32'h02);

`ifdef RR_ARB_LOCK_EN
        step(1'b0, 8'h00, 1'b0, 1'b0);
        step(1'b1, 8'b0001_0010, 1'b0, 1'b0);
        chk("lock_g0", 32'(gnt_onehot), 32'h02);
        step(1'b1, 8'b0001_0010, 1'b1, 1'b1);
        chk("lock_regrant", 32'(gnt_onehot), 32'h02);
        step(1'b1, 8'b0001_0010, 1'b1, 1'b0);
        chk("lock_release", 32'(gnt_onehot), 32'h10);
`endif

        // random traffic against the model
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 49) != 0),
                 N'($urandom),
                 ($urandom_range(0, 2) != 0),
                 ($urandom_range(0, 3) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_rr_onehot_arbiter
